udp_header_gen: RTL and testbench

UDP_HEADER_GEN -- requirements
Module: udp_header_gen

---
 rtl/eth_pkg.sv | 19 +
 rtl/ones_comp_sum16.sv | 23 ++
 rtl/udp_header_gen.sv | 145 ++++++++++++++
 tb/tb_udp_header_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP constants, FSM state encoding and checksum finishing helper.
package eth_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_SEND = 2'd2;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam logic [7:0]  UDP_PROTO     = 8'h11;
  localparam logic [15:0] UDP_LEN_MAX   = 16'd65527;

  // Complement of the folded sum; an all-zero checksum is transmitted as 0xFFFF.
  function automatic logic [15:0] csum_final(input logic [15:0] sum);
    return (sum == 16'hFFFF) ? 16'hFFFF : ~sum;
  endfunction

endpackage

// File: rtl/ones_comp_sum16.sv
// Combinational one's-complement sum of N 16-bit words, folded back to 16 bits.
module ones_comp_sum16 #(
  parameter int unsigned N = 2
) (
  input  logic [N*16-1:0] words,
  output logic [15:0]     sum
);

  logic [31:0] acc;
  logic [16:0] fold1;

  always_comb begin
    acc = '0;
    for (int i = 0; i < int'(N); i++) begin
      acc = acc + 32'(words[i*16 +: 16]);
    end
  end

  // Two folds suffice: the first leaves at most one carry, the second cannot overflow.
  assign fold1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
  assign sum   = fold1[15:0] + 16'(fold1[16]);

endmodule

// File: rtl/udp_header_gen.sv
// UDP header generator streaming the 8-byte header big-endian over an AXI-Stream-like port.
// Optional checksum computation is enabled by defining UDP_CSUM_EN.
module udp_header_gen
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [15:0]       port_s,
  input  logic [15:0]       port_d,
  input  logic [15:0]       udp_len,
`ifdef UDP_CSUM_EN
  input  logic [31:0]       ip_src,
  input  logic [31:0]       ip_dst,
  input  logic [15:0]       payload_sum,
`endif
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BEATS = UDP_HDR_BYTES / BYTES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      hdr_q, hdr_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;

  logic [16:0] len17;
  logic        len_bad;
  logic        accept;
  logic        hs;
  logic        last_beat;

  assign len17     = {1'b0, udp_len} + 17'd8;
  assign len_bad   = len17 > ({1'b0, UDP_LEN_MAX} + 17'd8);
  assign accept    = start && (state_q == ST_IDLE);
  assign hs        = (state_q == ST_SEND) && m_tready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef UDP_CSUM_EN
  logic [31:0] ip_src_q, ip_dst_q;
  logic [15:0] psum_q;
  logic [15:0] sum16;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ip_src_q <= '0;
      ip_dst_q <= '0;
      psum_q   <= '0;
    end else if (accept && !len_bad) begin
      ip_src_q <= ip_src;
      ip_dst_q <= ip_dst;
      psum_q   <= payload_sum;
    end
  end

  // Length appears twice: once in the pseudo-header, once in the UDP header proper.
  ones_comp_sum16 #(
    .N(10)
  ) u_sum (
    .words({ip_src_q[31:16], ip_src_q[15:0], ip_dst_q[31:16], ip_dst_q[15:0],
            {8'h00, UDP_PROTO}, hdr_q[31:16], hdr_q[31:16],
            hdr_q[63:48], hdr_q[47:32], psum_q}),
    .sum  (sum16)
  );
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            hdr_d = {port_s, port_d, len17[15:0], 16'h0000};
            cnt_d = '0;
`ifdef UDP_CSUM_EN
            state_d = ST_CALC;
`else
            state_d = ST_SEND;
`endif
          end
        end
      end
`ifdef UDP_CSUM_EN
      ST_CALC: begin
        hdr_d[15:0] = csum_final(sum16);
        state_d     = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (hs) begin
          hdr_d = hdr_q << DATA_W;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign m_tvalid = (state_q == ST_SEND);
  assign m_tlast  = m_tvalid && last_beat;
  assign m_tdata  = m_tvalid ? hdr_q[63 -: DATA_W] : '0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_udp_header_gen.sv
// Scoreboard bench for udp_header_gen at DATA_W = 8, 16 and 32.
module tb_udp_header_gen;

`ifdef UDP_CSUM_EN
  localparam int          CSUM_LAT = 1;
  localparam logic [15:0] CS_V1    = 16'h6182;  // ports 04D2/162E, len 4, psum 0
  localparam logic [15:0] CS_V2    = 16'hD087;  // ports ABCD/0035, len 0
  localparam logic [15:0] CS_MAX   = 16'h619A;  // ports 04D2/162E, len 65527
  localparam logic [15:0] CS_ZERO  = 16'hFFFF;  // psum 6182 forces computed 0
`else
  localparam int          CSUM_LAT = 0;
  localparam logic [15:0] CS_V1    = 16'h0000;
  localparam logic [15:0] CS_V2    = 16'h0000;
  localparam logic [15:0] CS_MAX   = 16'h0000;
  localparam logic [15:0] CS_ZERO  = 16'h0000;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [15:0] port_s = '0, port_d = '0, udp_len = '0;
  logic [31:0] ip_src = 32'hC0A8_0101, ip_dst = 32'hC0A8_0102;
  logic [15:0] payload_sum = '0;

  logic st8 = 0, st16 = 0, st32 = 0;
  logic r8 = 1, r16 = 1, r32 = 1;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;
  logic v8, v16, v32, l8, l16, l32;
  logic b8, b16, b32, dn8, dn16, dn32, e8, e16, e32;

  int checks = 0;
  int errors = 0;
  int dc8 = 0, dc16 = 0, dc32 = 0;
  logic [64:0] q8[$], q16[$], q32[$];
  logic stall_en = 0;

  always #5 aclk = ~aclk;

`ifdef UDP_CSUM_EN
  `define TB_CSUM_PORTS .ip_src(ip_src), .ip_dst(ip_dst), .payload_sum(payload_sum),
`else
  `define TB_CSUM_PORTS
`endif

  udp_header_gen #(.DATA_W(8)) u8 (
    .aclk(aclk), .aresetn(aresetn), .start(st8), .port_s(port_s), .port_d(port_d),
    .udp_len(udp_len), `TB_CSUM_PORTS .m_tdata(d8), .m_tvalid(v8), .m_tready(r8),
    .m_tlast(l8), .busy(b8), .done(dn8), .len_err(e8)
  );

  udp_header_gen #(.DATA_W(16)) u16 (
    .aclk(aclk), .aresetn(aresetn), .start(st16), .port_s(port_s), .port_d(port_d),
    .udp_len(udp_len), `TB_CSUM_PORTS .m_tdata(d16), .m_tvalid(v16), .m_tready(r16),
    .m_tlast(l16), .busy(b16), .done(dn16), .len_err(e16)
  );

  udp_header_gen #(.DATA_W(32)) u32 (
    .aclk(aclk), .aresetn(aresetn), .start(st32), .port_s(port_s), .port_d(port_d),
    .udp_len(udp_len), `TB_CSUM_PORTS .m_tdata(d32), .m_tvalid(v32), .m_tready(r32),
    .m_tlast(l32), .busy(b32), .done(dn32), .len_err(e32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Split a hand-written 64-bit header into DATA_W beats and queue them.
  task automatic push_hdr(input int w, input logic [63:0] hdr);
    logic [63:0] t;
    int beats;
    t = hdr;
    beats = 64 / w;
    for (int i = 0; i < beats; i++) begin
      logic [64:0] e;
      e = {(i == beats - 1), t >> (64 - w)};
      t = t << w;
      case (w)
        8:       q8.push_back(e);
        16:      q16.push_back(e);
        default: q32.push_back(e);
      endcase
    end
  endtask

  task automatic set_start(input int w, input logic val);
    case (w)
      8:       st8 = val;
      16:      st16 = val;
      default: st32 = val;
    endcase
  endtask

  task automatic pulse_start(input int w);
    @(posedge aclk); #1;
    set_start(w, 1'b1);
    @(posedge aclk); #1;
    set_start(w, 1'b0);
  endtask

  function automatic logic done_of(input int w);
    return (w == 8) ? dn8 : (w == 16) ? dn16 : dn32;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? b8 : (w == 16) ? b16 : b32;
  endfunction

  // Bounded wait for done; exp_n < 0 skips the latency comparison.
  task automatic wait_done(input string name, input int w, input int max, input int exp_n);
    int n;
    n = 0;
    while (n < max) begin
      @(negedge aclk);
      n++;
      if (done_of(w)) break;
    end
    if (!done_of(w)) begin
      checks++;
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, max);
    end else begin
      if (exp_n >= 0) chk({name, " done latency"}, 64'(n), 64'(exp_n));
      chk({name, " busy at done"}, 64'(busy_of(w)), 64'd0);
      @(negedge aclk);
      chk({name, " done one cycle"}, 64'(done_of(w)), 64'd0);
    end
  endtask

  // Monitors: pop and compare on every accepted beat.
  always @(negedge aclk) begin
    if (dn8) dc8++;
    if (dn16) dc16++;
    if (dn32) dc32++;
    if (aresetn && v8 && r8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL u8 unexpected beat: got %h", d8);
      end else begin
        logic [64:0] e;
        e = q8.pop_front();
        chk("u8 beat data", 64'(d8), 64'(e[7:0]));
        chk("u8 beat last", 64'(l8), 64'(e[64]));
      end
    end
    if (aresetn && v32 && r32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL u32 unexpected beat: got %h", d32);
      end else begin
        logic [64:0] e;
        e = q32.pop_front();
        chk("u32 beat data", 64'(d32), 64'(e[31:0]));
        chk("u32 beat last", 64'(l32), 64'(e[64]));
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic [15:0] prev_d16 = '0;
  logic        prev_l16 = 1'b0;

  always @(negedge aclk) begin
    if (aresetn && prev_stall) begin
      chk("u16 stall data hold", 64'(d16), 64'(prev_d16));
      chk("u16 stall last hold", 64'(l16), 64'(prev_l16));
    end
    prev_stall = aresetn && v16 && !r16;
    prev_d16   = d16;
    prev_l16   = l16;
    if (aresetn && v16 && r16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL u16 unexpected beat: got %h", d16);
      end else begin
        logic [64:0] e;
        e = q16.pop_front();
        chk("u16 beat data", 64'(d16), 64'(e[15:0]));
        chk("u16 beat last", 64'(l16), 64'(e[64]));
      end
    end
  end

  // Ready pattern 1,0,0,1 for the stall test.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge aclk); #1;
      if (stall_en) begin
        r16 = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        r16 = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset tdata", 64'(d8), 64'd0);
    chk("reset tvalid", 64'(v8), 64'd0);
    chk("reset tlast", 64'(l8), 64'd0);
    chk("reset busy", 64'(b8), 64'd0);
    chk("reset done", 64'(dn8), 64'd0);
    chk("reset len_err", 64'(e8), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Basic 8-bit header with back-to-back beats.
    port_s = 16'h04D2; port_d = 16'h162E; udp_len = 16'd4; payload_sum = 16'h0000;
    push_hdr(8, {48'h04D2_162E_000C, CS_V1});
    @(posedge aclk); #1;
    st8 = 1'b1;
    @(negedge aclk);
    chk("u8 valid before capture", 64'(v8), 64'd0);
    @(posedge aclk); #1;
    st8 = 1'b0;
    wait_done("u8 v1", 8, 40, 9 + CSUM_LAT);

    // 32-bit beats, tvalid latency, then the zero-checksum vector.
    push_hdr(32, {48'h04D2_162E_000C, CS_V1});
    @(posedge aclk); #1;
    st32 = 1'b1;
    @(negedge aclk);
    chk("u32 valid before capture", 64'(v32), 64'd0);
    @(posedge aclk); #1;
    st32 = 1'b0;
    @(negedge aclk);
    chk("u32 valid 1 cycle after", 64'(v32), 64'(CSUM_LAT == 0));
    if (CSUM_LAT != 0) begin
      @(negedge aclk);
      chk("u32 valid 2 cycles after", 64'(v32), 64'd1);
    end
    wait_done("u32 v1", 32, 20, -1);

    payload_sum = 16'h6182;
    push_hdr(32, {48'h04D2_162E_000C, CS_ZERO});
    pulse_start(32);
    wait_done("u32 zero csum", 32, 20, -1);
    payload_sum = 16'h0000;

    // Length rejection and maximal legal length.
    udp_len = 16'd65528;
    @(posedge aclk); #1;
    st8 = 1'b1;
    @(posedge aclk); #1;
    st8 = 1'b0;
    @(negedge aclk);
    chk("len_err pulse", 64'(e8), 64'd1);
    chk("len_err busy", 64'(b8), 64'd0);
    chk("len_err tvalid", 64'(v8), 64'd0);
    @(negedge aclk);
    chk("len_err one cycle", 64'(e8), 64'd0);
    repeat (4) @(negedge aclk);
    chk("len_err no beats", 64'(v8), 64'd0);

    udp_len = 16'd65527;
    push_hdr(8, {48'h04D2_162E_FFFF, CS_MAX});
    pulse_start(8);
    wait_done("u8 max len", 8, 40, 9 + CSUM_LAT);

    // Start mid-SEND and on the final handshake must both be ignored.
    udp_len = 16'd4;
    push_hdr(8, {48'h04D2_162E_000C, CS_V1});
    base = dc8;
    pulse_start(8);
    repeat (2) @(posedge aclk);
    #1;
    st8 = 1'b1; port_s = 16'hFFFF;
    @(posedge aclk); #1;
    st8 = 1'b0;
    repeat (4 + CSUM_LAT) @(posedge aclk);
    #1;
    st8 = 1'b1;
    @(posedge aclk); #1;
    st8 = 1'b0;
    repeat (12) @(negedge aclk);
    chk("ignored start done count", 64'(dc8 - base), 64'd1);
    chk("ignored start busy", 64'(b8), 64'd0);
    chk("ignored start queue", 64'(q8.size()), 64'd0);
    port_s = 16'h04D2;

    // Stalled 16-bit header.
    port_s = 16'hABCD; port_d = 16'h0035; udp_len = 16'd0;
    push_hdr(16, {48'hABCD_0035_0008, CS_V2});
    base = dc16;
    stall_en = 1'b1;
    pulse_start(16);
    wait_done("u16 stall", 16, 60, -1);
    stall_en = 1'b0;
    repeat (4) @(negedge aclk);
    chk("u16 done count", 64'(dc16 - base), 64'd1);
    chk("u16 queue drained", 64'(q16.size()), 64'd0);

    // Reset in the middle of SEND aborts without done.
    port_s = 16'h04D2; port_d = 16'h162E; udp_len = 16'd4;
    push_hdr(8, {48'h04D2_162E_000C, CS_V1});
    base = dc8;
    pulse_start(8);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    q8.delete();
    @(negedge aclk);
    chk("abort tvalid", 64'(v8), 64'd0);
    chk("abort tdata", 64'(d8), 64'd0);
    chk("abort tlast", 64'(l8), 64'd0);
    chk("abort busy", 64'(b8), 64'd0);
    chk("abort done", 64'(dn8), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (12) @(negedge aclk);
    chk("abort no done", 64'(dc8 - base), 64'd0);
    chk("abort idle", 64'(v8), 64'd0);

    chk("q8 empty", 64'(q8.size()), 64'd0);
    chk("q32 empty", 64'(q32.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
